// File: rtl/tlc_pkg.sv
// Shared definitions for the TLC configuration sequencer: FSM encoding,
// light index constants and the reset timing table.
package tlc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRed,
        StYel,
        StGrn,
        StDone
    } tlc_state_e;

    localparam logic [1:0] IDX_RED = 2'd0;
    localparam logic [1:0] IDX_YEL = 2'd1;
    localparam logic [1:0] IDX_GRN = 2'd2;
    localparam logic [1:0] IDX_BAD = 2'd3;

    localparam int unsigned DAY_RED   = 3;
    localparam int unsigned DAY_YEL   = 1;
    localparam int unsigned DAY_GRN   = 5;
    localparam int unsigned NIGHT_RED = 2;
    localparam int unsigned NIGHT_YEL = 1;
    localparam int unsigned NIGHT_GRN = 2;

endpackage

// File: rtl/tlc_cfg_table.sv
// Two-profile by three-light timing table with host write checking.
// Rejected writes leave the table untouched and pulse o_wr_err one cycle later.
module tlc_cfg_table
    import tlc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic                  i_wr_prof,
    input  logic [1:0]            i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_prof,
    output logic [DATA_WIDTH-1:0] o_rd_red,
    output logic [DATA_WIDTH-1:0] o_rd_yel,
    output logic [DATA_WIDTH-1:0] o_rd_grn,
    output logic                  o_wr_err
);

    logic [DATA_WIDTH-1:0] r_tbl [0:1][0:2];
    logic                  r_wr_err;
    logic                  w_bad;

    assign w_bad = i_wr && ((i_wr_data == '0) || (i_wr_idx == IDX_BAD));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tbl[0][0] <= DATA_WIDTH'(DAY_RED);
            r_tbl[0][1] <= DATA_WIDTH'(DAY_YEL);
            r_tbl[0][2] <= DATA_WIDTH'(DAY_GRN);
            r_tbl[1][0] <= DATA_WIDTH'(NIGHT_RED);
            r_tbl[1][1] <= DATA_WIDTH'(NIGHT_YEL);
            r_tbl[1][2] <= DATA_WIDTH'(NIGHT_GRN);
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= w_bad;
            if (i_wr && !w_bad) begin
                r_tbl[i_wr_prof][i_wr_idx] <= i_wr_data;
            end
        end
    end

    assign o_rd_red = r_tbl[i_rd_prof][IDX_RED];
    assign o_rd_yel = r_tbl[i_rd_prof][IDX_YEL];
    assign o_rd_grn = r_tbl[i_rd_prof][IDX_GRN];
    assign o_wr_err = r_wr_err;

endmodule

// File: rtl/tlc_cfg_seq.sv
// Loads a red/yellow/green timing profile into a traffic light controller as
// three valid/ready register writes, with reload queuing and per-beat timeout.
module tlc_cfg_seq
    import tlc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_RED    = 0,
    parameter int unsigned ADDR_YELLOW = 1,
    parameter int unsigned ADDR_GREEN  = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_host_wr,
    input  logic                  i_host_prof,
    input  logic [1:0]            i_host_idx,
    input  logic [DATA_WIDTH-1:0] i_host_data,
    input  logic                  i_prof_sel,
    input  logic                  i_load_req,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_active_prof,
    output logic                  o_wr_err,
    output logic                  o_tmo_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    tlc_state_e            r_state;
    tlc_state_e            w_state_nxt;
    logic                  r_snap_prof;
    logic [DATA_WIDTH-1:0] r_snap_red;
    logic [DATA_WIDTH-1:0] r_snap_yel;
    logic [DATA_WIDTH-1:0] r_snap_grn;
    logic                  r_active_prof;
    logic                  r_pend;
    logic                  r_boot;
    logic [CW-1:0]         r_wait;
    logic                  r_tmo_err;

    logic [DATA_WIDTH-1:0] w_rd_red;
    logic [DATA_WIDTH-1:0] w_rd_yel;
    logic [DATA_WIDTH-1:0] w_rd_grn;
    logic                  w_start;
    logic                  w_tmo;
    logic                  w_expire;
    logic                  w_grn_acc;

    tlc_cfg_table #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_table (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr     (i_host_wr),
        .i_wr_prof(i_host_prof),
        .i_wr_idx (i_host_idx),
        .i_wr_data(i_host_data),
        .i_rd_prof(i_prof_sel),
        .o_rd_red (w_rd_red),
        .o_rd_yel (w_rd_yel),
        .o_rd_grn (w_rd_grn),
        .o_wr_err (o_wr_err)
    );

    assign w_expire  = (r_wait == CW'(TIMEOUT - 1));
    assign w_grn_acc = (r_state == StGrn) && i_ready;

    always_comb begin
        w_state_nxt = r_state;
        o_valid     = 1'b0;
        o_addr      = '0;
        o_data      = '0;
        w_start     = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_boot || r_pend || i_load_req || (i_prof_sel != r_active_prof)) begin
                    w_start     = 1'b1;
                    w_state_nxt = StRed;
                end
            end
            StRed: begin
                o_valid = 1'b1;
                o_addr  = ADDR_WIDTH'(ADDR_RED);
                o_data  = r_snap_red;
                if (i_ready) begin
                    w_state_nxt = StYel;
                end else if (w_expire) begin
                    w_state_nxt = StIdle;
                    w_tmo       = 1'b1;
                end
            end
            StYel: begin
                o_valid = 1'b1;
                o_addr  = ADDR_WIDTH'(ADDR_YELLOW);
                o_data  = r_snap_yel;
                if (i_ready) begin
                    w_state_nxt = StGrn;
                end else if (w_expire) begin
                    w_state_nxt = StIdle;
                    w_tmo       = 1'b1;
                end
            end
            StGrn: begin
                o_valid = 1'b1;
                o_addr  = ADDR_WIDTH'(ADDR_GREEN);
                o_data  = r_snap_grn;
                if (i_ready) begin
                    w_state_nxt = StDone;
                end else if (w_expire) begin
                    w_state_nxt = StIdle;
                    w_tmo       = 1'b1;
                end
            end
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= StIdle;
            r_snap_prof   <= 1'b0;
            r_snap_red    <= '0;
            r_snap_yel    <= '0;
            r_snap_grn    <= '0;
            r_active_prof <= 1'b0;
            r_pend        <= 1'b0;
            r_boot        <= 1'b1;
            r_wait        <= '0;
            r_tmo_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_err <= w_tmo;
            if (w_start) begin
                r_snap_prof <= i_prof_sel;
                r_snap_red  <= w_rd_red;
                r_snap_yel  <= w_rd_yel;
                r_snap_grn  <= w_rd_grn;
                r_boot      <= 1'b0;
                r_pend      <= 1'b0;
            end else if (w_tmo) begin
                r_pend <= 1'b0;
            end else if ((r_state != StIdle) && i_load_req) begin
                r_pend <= 1'b1;
            end
            // Counts stalled cycles of the current beat only.
            if (o_valid && !i_ready && !w_expire) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_grn_acc) begin
                r_active_prof <= r_snap_prof;
            end
        end
    end

    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_active_prof = r_active_prof;
    assign o_tmo_err     = r_tmo_err;

endmodule

// File: tb/tb_tlc_cfg_seq.sv
// Scoreboard bench for tlc_cfg_seq: expected beats are queued with the stimulus
// and retired by a monitor on every accepted write.
module tb_tlc_cfg_seq;

    logic       clk;
    logic       rst;
    logic       host_wr;
    logic       host_prof;
    logic [1:0] host_idx;
    logic [7:0] host_data;
    logic       prof_sel;
    logic       load_req;
    logic [2:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic       active_prof;
    logic       wr_err;
    logic       tmo_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] sb[$];
    logic prev_grn = 1'b0;

    tlc_cfg_seq dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_host_wr    (host_wr),
        .i_host_prof  (host_prof),
        .i_host_idx   (host_idx),
        .i_host_data  (host_data),
        .i_prof_sel   (prof_sel),
        .i_load_req   (load_req),
        .o_addr       (addr),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_active_prof(active_prof),
        .o_wr_err     (wr_err),
        .o_tmo_err    (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push3(input int r, input int y, input int g);
        sb.push_back({3'd0, 8'(r)});
        sb.push_back({3'd1, 8'(y)});
        sb.push_back({3'd2, 8'(g)});
    endtask

    // Monitor: retire accepted beats and check done follows the green accept.
    always @(negedge clk) begin
        logic [10:0] e;
        if (prev_grn) check_eq("done_latency", done, 1);
        else if (done) check_eq("done_spurious", done, 0);
        prev_grn = valid && ready && (addr == 3'd2);
        if (valid && ready) begin
            if (sb.size() == 0) begin
                check_eq("beat_unexpected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("beat_addr", addr, e[10:8]);
                check_eq("beat_data", data, e[7:0]);
            end
        end
    end

    task automatic run_fast(input logic exp_prof);
        @(negedge clk);
        check_eq("idle_gap", valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("beat_consec", valid, 1);
        end
        @(negedge clk);
        check_eq("done_pulse", done, 1);
        check_eq("active_prof", active_prof, exp_prof);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_clear", busy, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic pulse_load();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int nv;
        int k;
        rst = 0; ready = 1; host_wr = 0; host_prof = 0; host_idx = 0; host_data = 0;
        prof_sel = 0; load_req = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_active", active_prof, 0);
        check_eq("rst_wr_err", wr_err, 0);
        check_eq("rst_tmo_err", tmo_err, 0);

        // Auto-load of the day profile on reset release
        push3(3, 1, 5);
        @(posedge clk); #1 rst = 1;
        run_fast(0);

        // Profile change while idle
        push3(2, 1, 2);
        @(posedge clk); #1 prof_sel = 1;
        run_fast(1);

        // Stall the yellow beat for five cycles
        push3(2, 1, 2);
        pulse_load();
        @(posedge clk); #1 ready = 0;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_valid", valid, 1);
            check_eq("stall_addr", addr, 1);
            check_eq("stall_data", data, 1);
        end
        @(posedge clk); #1 ready = 1;
        wait_done("stall_done");
        check_eq("stall_active", active_prof, 1);

        // Timeout on a stalled red beat, then retry
        @(posedge clk); #1 ready = 0; load_req = 1;
        @(posedge clk); #1 load_req = 0;
        nv = 0;
        k = 0;
        while (!tmo_err && k < 1200) begin
            @(negedge clk);
            if (valid) nv++;
            k++;
        end
        check_eq("tmo_pulse", tmo_err, 1);
        check_eq("tmo_valid_cycles", nv, 1024);
        check_eq("tmo_valid", valid, 0);
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_active", active_prof, 1);
        @(negedge clk);
        check_eq("tmo_one_cycle", tmo_err, 0);
        push3(2, 1, 2);
        @(posedge clk); #1 ready = 1; load_req = 1;
        @(posedge clk); #1 load_req = 0;
        wait_done("retry_done");
        check_eq("retry_active", active_prof, 1);

        // Host write plus reload request during a night load
        push3(2, 1, 2);
        push3(2, 1, 7);
        @(posedge clk); #1 load_req = 1;
        @(posedge clk); #1 load_req = 1; host_wr = 1; host_prof = 1; host_idx = 2; host_data = 7;
        @(posedge clk); #1 load_req = 0; host_wr = 0;
        @(negedge clk);
        check_eq("wr_ok_no_err", wr_err, 0);
        wait_done("pend_first_done");
        wait_done("pend_second_done");
        check_eq("pend_active", active_prof, 1);

        // Rejected host writes
        @(posedge clk); #1 host_wr = 1; host_prof = 0; host_idx = 0; host_data = 0;
        @(posedge clk); #1 host_wr = 0;
        @(negedge clk);
        check_eq("wr_err_zero", wr_err, 1);
        @(negedge clk);
        check_eq("wr_err_zero_clr", wr_err, 0);
        @(posedge clk); #1 host_wr = 1; host_prof = 0; host_idx = 3; host_data = 9;
        @(posedge clk); #1 host_wr = 0;
        @(negedge clk);
        check_eq("wr_err_idx3", wr_err, 1);
        @(negedge clk);
        check_eq("wr_err_idx3_clr", wr_err, 0);
        push3(3, 1, 5);
        @(posedge clk); #1 prof_sel = 0;
        wait_done("day_recheck_done");
        check_eq("day_recheck_active", active_prof, 0);

        // Reset in the middle of a stalled night load
        @(posedge clk); #1 ready = 0; prof_sel = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midrst_valid", valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_active", active_prof, 0);
        @(posedge clk); #1 ready = 1;
        push3(2, 1, 2);
        @(posedge clk); #1 rst = 1;
        wait_done("reboot_done");
        check_eq("reboot_active", active_prof, 1);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc_cfg_seq.md
TLC_CFG_SEQ -- requirements
Module: tlc_cfg_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line: ADDR_WIDTH, 3, TLC register address width.
REQ-002 DATA_WIDTH, 8, timing value width in seconds.
REQ-003 ADDR_RED / ADDR_YELLOW / ADDR_GREEN, 0 / 1 / 2, TLC register addresses.
REQ-004 TIMEOUT, 1024, max cycles to wait for ready per beat.
REQ-005 Ports (name, direction, width, meaning): clk, in, 1, single clock, all logic on posedge.
REQ-006 rst, in, 1, reset, synchronous, active-low (0 = reset).
REQ-007 host_wr, in, 1, table write strobe.
REQ-008 host_prof, in, 1, profile written (0 = day, 1 = night).
REQ-009 host_idx, in, 2, light index written (0 = red, 1 = yellow, 2 = green; 3 illegal).
REQ-010 host_data, in, DATA_WIDTH, timing value written.
REQ-011 prof_sel, in, 1, requested active profile.
REQ-012 load_req, in, 1, one-cycle pulse forcing a reload of prof_sel.
REQ-013 addr, out, ADDR_WIDTH, TLC register address.
REQ-014 data, out, DATA_WIDTH, TLC register data.
REQ-015 valid, out, 1, TLC write valid.
REQ-016 ready, in, 1, TLC write accept.
REQ-017 busy, out, 1, load in progress.
REQ-018 done, out, 1, one-cycle pulse after the green beat is accepted.
REQ-019 active_prof, out, 1, profile last loaded completely.
REQ-020 wr_err, out, 1, one-cycle pulse when a host write is rejected.
REQ-021 tmo_err, out, 1, one-cycle pulse when a load is aborted on timeout.

Function
REQ-022 Table holds 2 profiles x 3 values; a host write with host_data=0 or host_idx=3 is ignored and pulses wr_err in the next cycle.
REQ-023 Load triggers: exit from reset, load_req, or prof_sel differing from active_prof while idle.
REQ-024 FSM states: IDLE, RED, YEL, GRN, DONE.
REQ-025 IDLE -> RED on trigger; the selected profile is snapshotted in that same cycle.
REQ-026 RED -> YEL, YEL -> GRN, GRN -> DONE, each on valid&&ready at a posedge; DONE -> IDLE after one cycle.
REQ-027 In RED/YEL/GRN: valid=1, addr=ADDR_x, data=snapshot value, all held stable while ready=0.
REQ-028 Beat latency: with ready tied high the three beats occur on three consecutive cycles; done asserts the cycle after the GRN accept.
REQ-029 active_prof updates to the snapshot profile in the DONE cycle.
REQ-030 Host writes during a load update the table only; they do not affect the in-flight snapshot.
REQ-031 A trigger arriving while busy sets a single pending flag; the pending load starts from IDLE the cycle after DONE using the prof_sel value current then; multiple triggers collapse into one.
REQ-032 A per-beat wait counter resets on every accept; reaching TIMEOUT cycles without accept forces valid=0, a tmo_err pulse, and a return to IDLE; active_prof is unchanged and pending is cleared.
REQ-033 After a timeout, the next trigger (including prof_sel != active_prof) retries the full sequence from RED.
REQ-034 busy=1 in RED, YEL, GRN and DONE states.

Reset
REQ-035 While rst=0: state=IDLE, valid=0, addr=0, data=0, busy=0, done=0, wr_err=0, tmo_err=0, active_prof=0, pending=0, wait counter=0.
REQ-036 Reset table contents: day 3/1/5, night 2/1/2 (red/yellow/green).
REQ-037 First cycle after rst returns to 1: the auto-load trigger is taken and the load starts from RED.
REQ-038 Reset asserted mid-load aborts the load immediately; no done pulse is produced.

Structure
REQ-039 Shared package tlc_pkg holds the FSM state encoding, the light index constants (0/1/2) and the default timing values; the register addresses remain parameters.
REQ-040 One sub-module, tlc_cfg_table: 2x3 register file with the write check and wr_err generation.

Verification
REQ-041 Reset, release, ready=1 -> beats (0,3),(1,1),(2,5) on three consecutive cycles, done pulse, active_prof=0.
REQ-042 prof_sel 0->1 while idle -> beats (0,2),(1,1),(2,2), active_prof=1.
REQ-043 ready=0 for 5 cycles on the YEL beat -> addr=1 and data=1 held stable, then sequence completes.
REQ-044 ready=0 for 1024 cycles -> tmo_err pulse, valid=0, active_prof unchanged; ready=1 plus load_req -> full reload.
REQ-045 host write night/green=7 and load_req while loading night -> current load sends 2, pending reload sends 7.
REQ-046 host write with data=0 and with idx=3 -> wr_err pulse each time, table unchanged.
